// File: rtl/uart_in_pkg.sv
// Shared types and defaults for the UART receive-side word assembler.
package uart_in_pkg;

  localparam int WORD_BYTES_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/uart_in_word_fifo.sv
// First-word-fall-through word FIFO; head, valid and count are all registered.
module uart_in_word_fifo #(
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] head,
  output logic              head_valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_n_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_n_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_n_s;
  logic              valid_r;
  logic              pop_s;
  logic              push_s;

  assign pop_s      = valid_r & rd_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign wr_ready   = (count_r < CNT_W'(FIFO_DEPTH)) | pop_s;
  assign push_s     = wr_en & wr_ready;
  assign rd_ptr_n_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_n_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + CNT_W'(1);
      2'b01:   count_n_s = count_r - CNT_W'(1);
      default: count_n_s = count_r;
    endcase
  end

  // Next head: bypass the incoming word when it lands at the new read slot; hold when empty.
  always_comb begin
    head_n_s = head_r;
    if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
      head_n_s = wr_data;
    end else if (count_n_s != CNT_W'(0)) begin
      head_n_s = mem_r[rd_ptr_n_s];
    end else begin
      head_n_s = head_r;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {DATA_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_n_s;
      count_r  <= count_n_s;
      valid_r  <= (count_n_s != CNT_W'(0));
      head_r   <= head_n_s;
    end
  end

  assign head       = head_r;
  assign head_valid = valid_r;
  assign count      = count_r;

endmodule

// File: rtl/uart_in_interface.sv
// Collects UART RX bytes under a ready-to-receive handshake, packs them
// little-endian into words and queues complete words for the SoPU.
module uart_in_interface
  import uart_in_pkg::*;
#(
  parameter  int WORD_BYTES = WORD_BYTES_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int DATA_W     = 8 * WORD_BYTES,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              receive_enable,
  input  logic              uart_byte_valid,
  input  logic [7:0]        uart_byte_in,
  output logic              sop_to_uart_rtr,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clear_flags
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  state_e            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] asm_r;
  logic              rtr_r;
  logic              overflow_r;
  logic              push_req_s;
  logic              fifo_wr_ready_s;

  assign push_req_s = (state_r == PUSH);

  // Receive FSM; rtr is registered alongside the state so it is high exactly in COLLECT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      asm_r   <= {DATA_W{1'b0}};
      rtr_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          idx_r <= {IDX_W{1'b0}};
          asm_r <= {DATA_W{1'b0}};
          if (receive_enable) begin
            state_r <= COLLECT;
            rtr_r   <= 1'b1;
          end else begin
            rtr_r   <= 1'b0;
          end
        end
        COLLECT: begin
          if (uart_byte_valid) begin
            asm_r[8*idx_r +: 8] <= uart_byte_in;
            if (idx_r == LAST_IDX) begin
              state_r <= PUSH;
              rtr_r   <= 1'b0;
              idx_r   <= {IDX_W{1'b0}};
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
            end
          end else if (!receive_enable) begin
            // Abandon the partial word.
            state_r <= IDLE;
            rtr_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            asm_r   <= {DATA_W{1'b0}};
          end
        end
        PUSH: begin
          // The completed word survives receive_enable dropping; only FIFO space releases it.
          if (fifo_wr_ready_s) begin
            asm_r <= {DATA_W{1'b0}};
            if (receive_enable) begin
              state_r <= COLLECT;
              rtr_r   <= 1'b1;
            end else begin
              state_r <= IDLE;
              rtr_r   <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IDX_W{1'b0}};
          asm_r   <= {DATA_W{1'b0}};
          rtr_r   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a strobe while not ready; setting beats clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (uart_byte_valid && !rtr_r) begin
      overflow_r <= 1'b1;
    end else if (clear_flags) begin
      overflow_r <= 1'b0;
    end
  end

  uart_in_word_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (push_req_s),
    .wr_data    (asm_r),
    .wr_ready   (fifo_wr_ready_s),
    .rd_ready   (word_ready),
    .head       (word_out),
    .head_valid (word_valid),
    .count      (fifo_count)
  );

  assign sop_to_uart_rtr = rtr_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_uart_in_interface.sv
// Directed bench for uart_in_interface: a cycle table plus hand sequences.
module tb_uart_in_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        receive_enable;
  logic        uart_byte_valid;
  logic [7:0]  uart_byte_in;
  logic        sop_to_uart_rtr;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clear_flags;

  int total = 0;
  int bad   = 0;
  int maxc  = 0;

  typedef struct {
    logic        en;
    logic        v;
    logic [7:0]  b;
    logic        rdy;
    logic        clr;
    logic        rtr;
    logic        wv;
    logic [2:0]  cnt;
    logic [31:0] word;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];

  uart_in_interface dut (
    .clk             (clk),
    .rst             (rst),
    .receive_enable  (receive_enable),
    .uart_byte_valid (uart_byte_valid),
    .uart_byte_in    (uart_byte_in),
    .sop_to_uart_rtr (sop_to_uart_rtr),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .clear_flags     (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic en, input logic v, input logic [7:0] b,
                      input logic rdy, input logic clr);
    receive_enable  = en;
    uart_byte_valid = v;
    uart_byte_in    = b;
    word_ready      = rdy;
    clear_flags     = clr;
    @(posedge clk);
    #1;
    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, w[8*i +: 8], rdy, 1'b0);
    step(1'b1, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_words [5];
    logic [31:0] w;

    rst = 1'b0;
    receive_enable = 1'b0; uart_byte_valid = 1'b0; uart_byte_in = 8'h00;
    word_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rtr", {31'd0, sop_to_uart_rtr}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;

    //            en    v     byte   rdy   clr   rtr   wv    cnt   word           ovf
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,         1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h44332211, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h44332211, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h44332211, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h44332211, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h44332211, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h44332211, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h44332211, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].b, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("row%0d_rtr", i), {31'd0, sop_to_uart_rtr}, {31'd0, tbl[i].rtr});
      chk($sformatf("row%0d_valid", i), {31'd0, word_valid}, {31'd0, tbl[i].wv});
      chk($sformatf("row%0d_count", i), {29'd0, fifo_count}, {29'd0, tbl[i].cnt});
      chk($sformatf("row%0d_word", i), word_out, tbl[i].word);
      chk($sformatf("row%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
    end

    // Partial word discarded when receive_enable drops.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("disc_rtr", {31'd0, sop_to_uart_rtr}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("disc_count", {29'd0, fifo_count}, 32'd0);
    chk("disc_valid", {31'd0, word_valid}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send_word(32'h0D0C0B0A, 1'b0);
    chk("disc_word", word_out, 32'h0D0C0B0A);
    chk("disc_count1", {29'd0, fifo_count}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("disc_popped", {29'd0, fifo_count}, 32'd0);

    // Backpressure: five words into a four-deep FIFO.
    bp_words[0] = 32'hA3A2A1A0; bp_words[1] = 32'hB3B2B1B0; bp_words[2] = 32'hC3C2C1C0;
    bp_words[3] = 32'hD3D2D1D0; bp_words[4] = 32'hE3E2E1E0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_word(bp_words[k], 1'b0);
      chk($sformatf("bp_count%0d", k), {29'd0, fifo_count}, k + 1);
    end
    chk("bp_head", word_out, bp_words[0]);
    send_word(bp_words[4], 1'b0);
    chk("bp_hold_rtr", {31'd0, sop_to_uart_rtr}, 32'd0);
    chk("bp_hold_count", {29'd0, fifo_count}, 32'd4);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bp_hold_rtr2", {31'd0, sop_to_uart_rtr}, 32'd0);
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("bp_ovf_set", {31'd0, overflow}, 32'd1);
    chk("bp_ovf_rtr", {31'd0, sop_to_uart_rtr}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_ovf_clr", {31'd0, overflow}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_release_count", {29'd0, fifo_count}, 32'd4);
    chk("bp_release_rtr", {31'd0, sop_to_uart_rtr}, 32'd1);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("bp_drain%0d", k), word_out, bp_words[k]);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("bp_empty_count", {29'd0, fifo_count}, 32'd0);
    chk("bp_empty_valid", {31'd0, word_valid}, 32'd0);

    // Streaming with word_ready held high across pointer wrap.
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    maxc = 0;
    for (int k = 0; k < 16; k++) begin
      w = {8'(k), 8'hB0 ^ 8'(k), 8'h5A, 8'(k + 1)};
      send_word(w, 1'b1);
      chk($sformatf("stream_word%0d", k), word_out, w);
      chk($sformatf("stream_valid%0d", k), {31'd0, word_valid}, 32'd1);
    end
    chk("stream_maxcnt", maxc, 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", {29'd0, fifo_count}, 32'd0);

    // Asynchronous reset mid-word with two words buffered.
    send_word(32'h12345678, 1'b0);
    send_word(32'h9ABCDEF0, 1'b0);
    chk("rst2_pre_count", {29'd0, fifo_count}, 32'd2);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    receive_enable = 1'b0; uart_byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst2_rtr", {31'd0, sop_to_uart_rtr}, 32'd0);
    chk("rst2_valid", {31'd0, word_valid}, 32'd0);
    chk("rst2_word", word_out, 32'd0);
    chk("rst2_count", {29'd0, fifo_count}, 32'd0);
    chk("rst2_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst2_idle", {31'd0, sop_to_uart_rtr}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst2_collect", {31'd0, sop_to_uart_rtr}, 32'd1);
    send_word(32'h04030201, 1'b0);
    chk("rst2_word_after", word_out, 32'h04030201);
    chk("rst2_count_after", {29'd0, fifo_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
